// File: rtl/move_writeback.sv
// move_writeback: serialises move/swap results onto one register-file
// write port, result 0 first, then pulses done.
module move_writeback #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_wr0,
  input  logic                 in_wr1,
  input  logic [REG_IDX_W-1:0] in_dst0,
  input  logic [REG_IDX_W-1:0] in_dst1,
  input  logic [DATA_W-1:0]    in_data0,
  input  logic [DATA_W-1:0]    in_data1,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   wr0_q, wr0_d;
  logic                   wr1_q, wr1_d;
  logic [REG_IDX_W-1:0]   dst0_q, dst0_d;
  logic [REG_IDX_W-1:0]   dst1_q, dst1_d;
  logic [DATA_W-1:0]      data0_q, data0_d;
  logic [DATA_W-1:0]      data1_q, data1_d;

  logic accept;
  logic eff_wr0;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // XCHG of a register with itself commits only result 1
  assign eff_wr0 = in_wr0 && !(in_wr1 && (in_dst0 == in_dst1));

  always_comb begin
    state_d = state_q;
    wr0_d   = wr0_q;
    wr1_d   = wr1_q;
    dst0_d  = dst0_q;
    dst1_d  = dst1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr0_d   = eff_wr0;
          wr1_d   = in_wr1;
          dst0_d  = in_dst0;
          dst1_d  = in_dst1;
          data0_d = in_data0;
          data1_d = in_data1;
          if (eff_wr0) begin
            state_d = S_WR0;
          end else if (in_wr1) begin
            state_d = S_WR1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR0:   state_d = wr1_q ? S_WR1 : S_DONE;
      S_WR1:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    done     = 1'b0;
    unique case (state_q)
      S_WR0: begin
        rf_we    = wr0_q;
        rf_waddr = dst0_q;
        rf_wdata = data0_q;
      end
      S_WR1: begin
        rf_we    = wr1_q;
        rf_waddr = dst1_q;
        rf_wdata = data1_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr0_q   <= 1'b0;
      wr1_q   <= 1'b0;
      dst0_q  <= '0;
      dst1_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      wr0_q   <= wr0_d;
      wr1_q   <= wr1_d;
      dst0_q  <= dst0_d;
      dst1_q  <= dst1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

endmodule

// File: tb/tb_move_writeback.sv
// tb_move_writeback: directed bench with a per-transaction cycle model
// and literal checks at the points called out for each scenario.
module tb_move_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wr0;
  logic        in_wr1;
  logic [2:0]  in_dst0;
  logic [2:0]  in_dst1;
  logic [31:0] in_data0;
  logic [31:0] in_data1;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  move_writeback #(.DATA_W(32), .REG_IDX_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wr0   (in_wr0),
    .in_wr1   (in_wr1),
    .in_dst0  (in_dst0),
    .in_dst1  (in_dst1),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .done     (done)
  );

  // One entry per busy cycle that follows an accepted bundle.
  typedef struct {
    logic        we;
    logic [2:0]  a;
    logic [31:0] d;
    logic        dn;
  } cyc_t;

  cyc_t q[$];
  logic same;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (in_valid) begin
      same = in_wr0 && in_wr1 && (in_dst0 == in_dst1);
      if (in_wr0 && !same)
        q.push_back('{1'b1, in_dst0, in_data0, 1'b0});
      if (in_wr1)
        q.push_back('{1'b1, in_dst1, in_data1, 1'b0});
      q.push_back('{1'b0, 3'd0, 32'd0, 1'b1});
    end
  end

  cyc_t e;
  logic e_rdy;

  always @(negedge clk) begin
    if (rst) begin
      e = '{1'b0, 3'd0, 32'd0, 1'b0};
      e_rdy = 1'b0;
    end else if (q.size() > 0) begin
      e = q[0];
      e_rdy = 1'b0;
    end else begin
      e = '{1'b0, 3'd0, 32'd0, 1'b0};
      e_rdy = 1'b1;
    end
    checks++;
    if (rf_we !== e.we || rf_waddr !== e.a || rf_wdata !== e.d ||
        done !== e.dn || in_ready !== e_rdy) begin
      errors++;
      $display("FAIL cycle t=%0t got we=%b a=%0d d=%h dn=%b rdy=%b exp we=%b a=%0d d=%h dn=%b rdy=%b",
               $time, rf_we, rf_waddr, rf_wdata, done, in_ready,
               e.we, e.a, e.d, e.dn, e_rdy);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bundle(input logic w0, input logic w1,
                        input logic [2:0] d0, input logic [2:0] d1,
                        input logic [31:0] x0, input logic [31:0] x1);
    in_valid = 1'b1;
    in_wr0   = w0;
    in_wr1   = w1;
    in_dst0  = d0;
    in_dst1  = d1;
    in_data0 = x0;
    in_data1 = x1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_wr0   = 1'b0;
    in_wr1   = 1'b0;
    in_dst0  = 3'd0;
    in_dst1  = 3'd0;
    in_data0 = 32'd0;
    in_data1 = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c1;
    int c2;
    logic acc;
    rst = 1'b1;
    idle_in();
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    // MOV
    bundle(1'b1, 1'b0, 3'd3, 3'd0, 32'h12345678, 32'h0);
    step();
    idle_in();
    chk("mov_we", {31'd0, rf_we}, 32'd1);
    chk("mov_addr", {29'd0, rf_waddr}, 32'd3);
    chk("mov_data", rf_wdata, 32'h12345678);
    step();
    chk("mov_done", {31'd0, done}, 32'd1);
    chk("mov_we_off", {31'd0, rf_we}, 32'd0);
    step();
    chk("mov_ready_back", {31'd0, in_ready}, 32'd1);

    // XCHG distinct registers
    bundle(1'b1, 1'b1, 3'd1, 3'd2, 32'hAAAA0000, 32'h0000BBBB);
    step();
    idle_in();
    chk("xchg_a0", {29'd0, rf_waddr}, 32'd1);
    chk("xchg_d0", rf_wdata, 32'hAAAA0000);
    step();
    chk("xchg_a1", {29'd0, rf_waddr}, 32'd2);
    chk("xchg_d1", rf_wdata, 32'h0000BBBB);
    step();
    chk("xchg_done", {31'd0, done}, 32'd1);
    step();

    // XCHG register with itself
    bundle(1'b1, 1'b1, 3'd5, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    step();
    idle_in();
    chk("same_we", {31'd0, rf_we}, 32'd1);
    chk("same_addr", {29'd0, rf_waddr}, 32'd5);
    chk("same_data", rf_wdata, 32'hDEADBEEF);
    step();
    chk("same_done", {31'd0, done}, 32'd1);
    step();

    // sign-fill, in_valid held across two bundles
    c1 = -1;
    c2 = -1;
    bundle(1'b1, 1'b0, 3'd7, 3'd0, 32'hFFFFFFFF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        if (c1 < 0) begin
          c1 = i;
          bundle(1'b1, 1'b0, 3'd6, 3'd0, 32'hFFFF8000, 32'h0);
        end else if (c2 < 0) begin
          c2 = i;
          idle_in();
        end
      end
    end
    chk("b2b_spacing", c2 - c1, 32'd3);

    // zero-write bundle
    bundle(1'b0, 1'b0, 3'd4, 3'd4, 32'h1, 32'h2);
    step();
    idle_in();
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("zero_ready", {31'd0, in_ready}, 32'd1);

    // reset during WR0 of an XCHG
    bundle(1'b1, 1'b1, 3'd1, 3'd2, 32'h11111111, 32'h22222222);
    step();
    idle_in();
    chk("rmid_we_pre", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid_we_drop", {31'd0, rf_we}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rmid_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("rmid_no_wr1", {31'd0, rf_we}, 32'd0);
    chk("rmid_no_done", {31'd0, done}, 32'd0);

    // reset on the same edge as an accept
    bundle(1'b1, 1'b0, 3'd2, 3'd0, 32'hCAFEF00D, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_in();
    #1;
    chk("rsame_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("rsame_no_wr", {31'd0, rf_we}, 32'd0);
    chk("rsame_no_done", {31'd0, done}, 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
